uart_buffered_port: RTL and testbench

- Next-generation buffered UART port: wraps the existing `uart` serial core with depth-parametrised TX/RX FIFOs.
- Adds a handshaked transmit sequencer that pops exactly one byte per UART frame.
- Exposes fill levels, sticky overrun/overflow/frame error flags and a maskable, threshold-based interrupt.
- Sits between the `uart` core and any host-side controller.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_buffered_port_if.sv | 36 +++
 rtl/uart.sv | 134 +++++++++++++
 rtl/uart_sync_fifo.sv | 58 +++++
 rtl/uart_buffered_port.sv | 145 ++++++++++++++
 tb/tb_uart_buffered_port.sv | 299 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART port.
package uart_pkg;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_WAIT_START,
    TX_WAIT_DONE
  } tx_state_e;

  // Bit positions inside irq_en and the internal interrupt source vector.
  localparam int unsigned IRQ_RX_WM = 0;
  localparam int unsigned IRQ_TX_LW = 1;
  localparam int unsigned IRQ_OVR   = 2;
  localparam int unsigned IRQ_FRM   = 3;

  // Cycles WAIT_START waits for the core to report is_transmitting.
  localparam int unsigned START_TIMEOUT = 4;

endpackage

// File: rtl/uart_buffered_port_if.sv
// Host-side bus of the buffered UART port.
interface uart_buffered_port_if #(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
);
  localparam int unsigned TLW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RLW = $clog2(RX_DEPTH) + 1;

  logic [7:0]     tx_data;
  logic           tx_push;
  logic           tx_full;
  logic [TLW-1:0] tx_level;
  logic [7:0]     rx_data;
  logic           rx_pop;
  logic           rx_empty;
  logic [RLW-1:0] rx_level;
  logic [3:0]     irq_en;
  logic           err_clear;
  logic           overrun_err;
  logic           tx_overflow;
  logic           frame_err;
  logic           irq;
  logic           busy;

  modport master (
    output tx_data, tx_push, rx_pop, irq_en, err_clear,
    input  tx_full, tx_level, rx_data, rx_empty, rx_level,
           overrun_err, tx_overflow, frame_err, irq, busy
  );

  modport slave (
    input  tx_data, tx_push, rx_pop, irq_en, err_clear,
    output tx_full, tx_level, rx_data, rx_empty, rx_level,
           overrun_err, tx_overflow, frame_err, irq, busy
  );
endinterface

// File: rtl/uart.sv
// Serial UART core: 8N1, LSB first, CLKS_PER_BIT clocks per bit.
module uart #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shift_q, tx_shift_d;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic          rx_busy_q, rx_busy_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          received_q, received_d;
  logic          recv_error_q, recv_error_d;

  // Transmitter: shift out {stop, data, start} one bit per baud period.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_shift_d = {1'b1, tx_shift_q[9:1]};
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CW'(1);
      end
    end else if (transmit) begin
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shift_d = {1'b1, tx_byte, 1'b0};
    end
  end

  // Receiver: start on a falling edge, sample mid-bit, check the stop bit.
  // Requiring a falling edge keeps a low line after a bad stop bit from
  // being taken as a new start bit.
  always_comb begin
    rx_busy_d    = rx_busy_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;
    if (rx_busy_q) begin
      if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d = '0;
        if (rx_bit_q == 4'd0) begin
          if (rx_sync_q) rx_busy_d = 1'b0;
          else           rx_bit_d  = 4'd1;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_d = 1'b0;
          if (rx_sync_q) received_d   = 1'b1;
          else           recv_error_d = 1'b1;
        end else begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + CW'(1);
      end
    end else if (rx_prev_q && !rx_sync_q) begin
      rx_busy_d = 1'b1;
      rx_cnt_d  = BIT_HALF;
      rx_bit_d  = '0;
    end
  end

  // Core state registers and input synchroniser.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_busy_q    <= 1'b0;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '1;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_busy_q    <= 1'b0;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      received_q   <= 1'b0;
      recv_error_q <= 1'b0;
    end else begin
      tx_busy_q    <= tx_busy_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_busy_q    <= rx_busy_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      received_q   <= received_d;
      recv_error_q <= recv_error_d;
    end
  end

  assign tx              = tx_busy_q ? tx_shift_q[0] : 1'b1;
  assign received        = received_q;
  assign recv_error      = recv_error_q;
  assign rx_byte         = rx_shift_q;
  assign is_receiving    = rx_busy_q;
  assign is_transmitting = tx_busy_q;

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word fall-through FIFO with registered occupancy.
module uart_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           level_q, level_d;
  logic                  do_wr, do_rd;

  // A write into a full FIFO is accepted only when a read frees a slot.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (do_wr && !do_rd) level_d = level_q + (AW+1)'(1);
    if (!do_wr && do_rd) level_d = level_q - (AW+1)'(1);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;

endmodule

// File: rtl/uart_buffered_port.sv
// Buffered UART port: TX/RX FIFOs, TX sequencer, sticky errors, interrupt.
module uart_buffered_port
  import uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned RX_DEPTH     = 16,
  parameter int unsigned RX_THRESH    = 8,
  parameter int unsigned TX_THRESH    = 2,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  uart_buffered_port_if.slave host
);
  localparam int unsigned TLW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned RLW = $clog2(RX_DEPTH) + 1;

  logic [7:0]     tx_head;
  logic           tx_full, tx_empty, tx_pop;
  logic [TLW-1:0] tx_level;
  logic [7:0]     rx_head;
  logic           rx_full, rx_empty;
  logic [RLW-1:0] rx_level;

  logic       core_transmit, core_received, core_recv_error;
  logic       core_is_receiving, core_is_transmitting;
  logic [7:0] core_rx_byte;

  tx_state_e  state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic       overrun_q, overrun_d;
  logic       overflow_q, overflow_d;
  logic       frame_q, frame_d;
  logic       irq_q, irq_d;
  logic       rx_wm, tx_lw;
  logic [3:0] irq_src;

  uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst),
    .wr_en(host.tx_push), .wr_data(host.tx_data),
    .rd_en(tx_pop), .rd_data(tx_head),
    .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst),
    .wr_en(core_received), .wr_data(core_rx_byte),
    .rd_en(host.rx_pop), .rd_data(rx_head),
    .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .transmit(core_transmit), .tx_byte(tx_head),
    .received(core_received), .rx_byte(core_rx_byte),
    .is_receiving(core_is_receiving), .is_transmitting(core_is_transmitting),
    .recv_error(core_recv_error)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Sequencer next state: one pop per frame, guarded start wait.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      TX_IDLE: if (!tx_empty) state_d = TX_LOAD;
      TX_LOAD: begin
        state_d    = TX_WAIT_START;
        wait_cnt_d = '0;
      end
      TX_WAIT_START: begin
        if (core_is_transmitting || wait_cnt_q == 3'(START_TIMEOUT - 1))
          state_d = TX_WAIT_DONE;
        else
          wait_cnt_d = wait_cnt_q + 3'd1;
      end
      TX_WAIT_DONE: if (!core_is_transmitting) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  // Sequencer outputs: LOAD starts the core and pops the FIFO head.
  always_comb begin
    core_transmit = (state_q == TX_LOAD);
    tx_pop        = (state_q == TX_LOAD);
  end

  // Sticky flag next values; a new event wins over err_clear.
  always_comb begin
    overflow_d = (host.tx_push && tx_full && !tx_pop) || (overflow_q && !host.err_clear);
    overrun_d  = (core_received && rx_full && !host.rx_pop) || (overrun_q && !host.err_clear);
    frame_d    = core_recv_error || (frame_q && !host.err_clear);
  end

  // Interrupt sources from current levels and flags.
  always_comb begin
    rx_wm              = (rx_level >= RLW'(RX_THRESH));
    tx_lw              = (tx_level <= TLW'(TX_THRESH));
    irq_src            = '0;
    irq_src[IRQ_RX_WM] = rx_wm;
    irq_src[IRQ_TX_LW] = tx_lw;
    irq_src[IRQ_OVR]   = overrun_q;
    irq_src[IRQ_FRM]   = frame_q;
    irq_d              = |(irq_src & host.irq_en);
  end

  // Flag and interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
      frame_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      overrun_q  <= overrun_d;
      frame_q    <= frame_d;
      irq_q      <= irq_d;
    end
  end

  assign host.tx_full     = tx_full;
  assign host.tx_level    = tx_level;
  assign host.rx_data     = rx_head;
  assign host.rx_empty    = rx_empty;
  assign host.rx_level    = rx_level;
  assign host.overrun_err = overrun_q;
  assign host.tx_overflow = overflow_q;
  assign host.frame_err   = frame_q;
  assign host.irq         = irq_q;
  assign host.busy        = core_is_receiving || core_is_transmitting || (state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_buffered_port.sv
// Randomized bench for uart_buffered_port with a serial line model.
module tb_uart_buffered_port;
  localparam int TX_DEPTH  = 16;
  localparam int RX_DEPTH  = 16;
  localparam int RX_THRESH = 8;
  localparam int TX_THRESH = 2;
  localparam int CPB       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;
  logic tx_line;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mon_q[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] mon_byte;

  uart_buffered_port_if #(.TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) host ();

  uart_buffered_port #(
    .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH),
    .RX_THRESH(RX_THRESH), .TX_THRESH(TX_THRESH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx_line), .tx(tx_line), .host(host)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decode frames appearing on the DUT's serial output.
  initial begin : tx_monitor
    forever begin
      @(negedge tx_line);
      repeat (CPB / 2) @(posedge clk);
      #1;
      if (tx_line == 1'b0) begin
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(posedge clk);
          #1;
          mon_byte[b] = tx_line;
        end
        repeat (CPB) @(posedge clk);
        #1;
        mon_q.push_back(mon_byte);
      end
    end
  end

  task automatic ser_send(input logic [7:0] b, input bit good_stop);
    rx_line = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) tick();
    end
    rx_line = good_stop;
    repeat (CPB) tick();
    rx_line = 1'b1;
    repeat (2) tick();
  endtask

  // Reference RX behaviour for a clean frame with no concurrent pop.
  task automatic rx_good(input logic [7:0] b);
    ser_send(b, 1'b1);
    if (rxq.size() < RX_DEPTH) rxq.push_back(b);
  endtask

  task automatic push_byte(input logic [7:0] b);
    host.tx_data = b;
    host.tx_push = 1'b1;
    tick();
    host.tx_push = 1'b0;
  endtask

  task automatic pop_byte();
    host.rx_pop = 1'b1;
    tick();
    host.rx_pop = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int i = 0;
    while (mon_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    check_eq("frames_seen", mon_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (host.busy && i < budget) begin
      tick();
      i++;
    end
    check_eq("idle_reached", host.busy, 1'b0);
  endtask

  // Pulse rx_pop or err_clear in the cycle the core reports a frame.
  task automatic pulse_on_event(input bit on_err, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < CPB * 12 && !seen; i++) begin
      tick();
      if ((on_err ? dut.core_recv_error : dut.core_received) == 1'b1) begin
        if (on_err) host.err_clear = 1'b1;
        else        host.rx_pop    = 1'b1;
        seen = 1'b1;
        tick();
        host.err_clear = 1'b0;
        host.rx_pop    = 1'b0;
      end
    end
  endtask

  initial begin : main
    logic [7:0] b;
    bit seen;
    host.tx_data   = '0;
    host.tx_push   = 1'b0;
    host.rx_pop    = 1'b0;
    host.irq_en    = 4'b0010;
    host.err_clear = 1'b0;

    // Reset values, then tx_lw interrupt from an empty TX FIFO.
    apply_reset();
    check_eq("rst_tx_level", host.tx_level, 0);
    check_eq("rst_tx_full", host.tx_full, 0);
    check_eq("rst_rx_empty", host.rx_empty, 1);
    check_eq("rst_rx_level", host.rx_level, 0);
    check_eq("rst_flags", {host.overrun_err, host.tx_overflow, host.frame_err}, 0);
    check_eq("rst_irq", host.irq, 0);
    check_eq("rst_busy", host.busy, 0);
    check_eq("rst_tx_line", tx_line, 1);
    tick();
    check_eq("irq_tx_lw", host.irq, 1);
    host.irq_en = 4'b0000;
    tick();

    // Three queued bytes leave in order.
    mon_q.delete();
    txq = '{8'h55, 8'hA3, 8'h0F};
    push_byte(8'h55);
    check_eq("tx_level_1", host.tx_level, 1);
    push_byte(8'hA3);
    check_eq("tx_level_2", host.tx_level, 2);
    push_byte(8'h0F);
    wait_frames(3, 3 * CPB * 12);
    wait_idle(CPB * 12);
    check_eq("tx3_level_end", host.tx_level, 0);
    for (int i = 0; i < 3 && i < mon_q.size(); i++)
      check_eq("tx3_byte", mon_q[i], txq[i]);
    repeat (CPB * 12) tick();
    check_eq("tx3_no_extra", mon_q.size(), 3);

    // Fill the TX FIFO behind an in-flight frame, then overflow it.
    mon_q.delete();
    txq.delete();
    b = 8'($urandom);
    push_byte(b);
    txq.push_back(b);
    for (int i = 0; i < 20 && host.tx_level != 0; i++) tick();
    check_eq("primer_popped", host.tx_level, 0);
    for (int i = 1; i <= TX_DEPTH + 1; i++) begin
      b = 8'($urandom);
      push_byte(b);
      if (i <= TX_DEPTH) begin
        txq.push_back(b);
        check_eq("fill_level", host.tx_level, i);
        check_eq("fill_full", host.tx_full, (i == TX_DEPTH) ? 1 : 0);
        check_eq("fill_ovf", host.tx_overflow, 0);
      end else begin
        check_eq("ovf_level", host.tx_level, TX_DEPTH);
        check_eq("ovf_flag", host.tx_overflow, 1);
      end
    end
    host.err_clear = 1'b1;
    tick();
    host.err_clear = 1'b0;
    check_eq("ovf_cleared", host.tx_overflow, 0);
    wait_frames(TX_DEPTH + 1, (TX_DEPTH + 1) * CPB * 12);
    for (int i = 0; i < txq.size() && i < mon_q.size(); i++)
      check_eq("ovf_stream", mon_q[i], txq[i]);
    wait_idle(CPB * 12);
    repeat (CPB * 12) tick();
    check_eq("ovf_no_17th", mon_q.size(), TX_DEPTH + 1);

    // RX watermark interrupt, overrun and pop-on-receive.
    apply_reset();
    host.irq_en = 4'b0001;
    rxq.delete();
    pop_byte();
    check_eq("pop_empty_level", host.rx_level, 0);
    check_eq("pop_empty_flag", host.rx_empty, 1);
    for (int i = 0; i < RX_THRESH - 1; i++) rx_good(8'($urandom));
    check_eq("rx7_level", host.rx_level, rxq.size());
    check_eq("rx7_irq", host.irq, 0);
    rx_good(8'($urandom));
    check_eq("rx8_level", host.rx_level, rxq.size());
    check_eq("rx8_irq", host.irq, 1);
    check_eq("rx8_head", host.rx_data, rxq[0]);
    pop_byte();
    void'(rxq.pop_front());
    check_eq("pop_level", host.rx_level, rxq.size());
    check_eq("pop_irq_lag", host.irq, 1);
    tick();
    check_eq("pop_irq_drop", host.irq, 0);
    while (rxq.size() < RX_DEPTH) rx_good(8'($urandom));
    check_eq("rx_full_level", host.rx_level, RX_DEPTH);
    check_eq("rx_full_ovr", host.overrun_err, 0);
    rx_good(8'($urandom));
    check_eq("ovr_level", host.rx_level, RX_DEPTH);
    check_eq("ovr_flag", host.overrun_err, 1);
    check_eq("ovr_head", host.rx_data, rxq[0]);
    host.err_clear = 1'b1;
    tick();
    host.err_clear = 1'b0;
    check_eq("ovr_cleared", host.overrun_err, 0);
    b = 8'($urandom);
    fork
      ser_send(b, 1'b1);
      pulse_on_event(1'b0, seen);
    join
    check_eq("por_seen", seen, 1);
    void'(rxq.pop_front());
    rxq.push_back(b);
    check_eq("por_level", host.rx_level, RX_DEPTH);
    check_eq("por_no_ovr", host.overrun_err, 0);
    while (rxq.size() > 0) begin
      check_eq("drain_data", host.rx_data, rxq[0]);
      pop_byte();
      void'(rxq.pop_front());
    end
    check_eq("drain_empty", host.rx_empty, 1);

    // Frame error is sticky and beats a same-cycle clear.
    host.irq_en = 4'b1000;
    ser_send(8'h3C, 1'b0);
    check_eq("ferr_flag", host.frame_err, 1);
    check_eq("ferr_level", host.rx_level, 0);
    check_eq("ferr_irq", host.irq, 1);
    host.err_clear = 1'b1;
    tick();
    host.err_clear = 1'b0;
    check_eq("ferr_cleared", host.frame_err, 0);
    fork
      ser_send(8'($urandom), 1'b0);
      pulse_on_event(1'b1, seen);
    join
    check_eq("ferr2_seen", seen, 1);
    check_eq("ferr_set_wins", host.frame_err, 1);
    check_eq("ferr2_level", host.rx_level, 0);
    host.irq_en = 4'b0000;

    // Reset in the middle of a frame with bytes still queued.
    apply_reset();
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    repeat (20) tick();
    check_eq("mid_level", host.tx_level, 5);
    check_eq("mid_busy", host.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_level", host.tx_level, 0);
    check_eq("abort_busy", host.busy, 0);
    check_eq("abort_tx_line", tx_line, 1);
    repeat (CPB * 12) tick();
    mon_q.delete();
    repeat (CPB * 40) tick();
    check_eq("abort_no_frames", mon_q.size(), 0);
    check_eq("abort_level_end", host.tx_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
